// File: rtl/perf_counter_reader_pkg.sv
// Shared constants for the performance-counter read port: data width,
// request select codes and the handshake FSM state encoding.
package perf_counter_reader_pkg;

    localparam int PERF_W = 20;

    localparam logic [1:0] SEL_INSTR = 2'd0;
    localparam logic [1:0] SEL_MACC  = 2'd1;
    localparam logic [1:0] SEL_MCORR = 2'd2;
    localparam logic [1:0] SEL_SNAP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } perf_state_e;

endpackage

// File: rtl/perf_snapshot_bank.sv
// Snapshot registers for the three event counters plus a read mux.
// With PERF_READ_DELTA_EN defined, each capture stores the increment since the previous capture.
module perf_snapshot_bank
    import perf_counter_reader_pkg::*;
#(
    parameter int WIDTH = PERF_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             capture,
    input  logic [WIDTH-1:0] live_instr,
    input  logic [WIDTH-1:0] live_macc,
    input  logic [WIDTH-1:0] live_mcorr,
    input  logic [1:0]       rd_sel,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] live [3];
    logic [WIDTH-1:0] snap [3];

    assign live[0] = live_instr;
    assign live[1] = live_macc;
    assign live[2] = live_mcorr;

`ifdef PERF_READ_DELTA_EN
    logic [WIDTH-1:0] prev [3];

    // Unsigned subtraction wraps, so a counter rolling over between captures still yields the true increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) begin
                snap[k] <= '0;
                prev[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < 3; k++) begin
                snap[k] <= live[k] - prev[k];
                prev[k] <= live[k];
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) begin
                snap[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < 3; k++) begin
                snap[k] <= live[k];
            end
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        case (rd_sel)
            SEL_INSTR: rd_data = snap[0];
            SEL_MACC:  rd_data = snap[1];
            SEL_MCORR: rd_data = snap[2];
            default:   rd_data = '0;
        endcase
    end

endmodule

// File: rtl/perf_counter_reader.sv
// Read-side port for the event counters: atomic SNAPSHOT plus per-word reads over a
// valid/ready request/response handshake. Optional delta mode: PERF_READ_DELTA_EN.
module perf_counter_reader
    import perf_counter_reader_pkg::*;
#(
    parameter int WIDTH = PERF_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] instruction_count,
    input  logic [WIDTH-1:0] memory_access_count,
    input  logic [WIDTH-1:0] memory_correction_count,
    input  logic             req_valid,
    input  logic [1:0]       req_sel,
    output logic             req_ready,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    input  logic             rsp_ready
);

    perf_state_e      state;
    logic [1:0]       sel_q;
    logic             accept;
    logic             capture;
    logic [WIDTH-1:0] bank_data;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign accept    = req_valid && req_ready;
    // Capture on the accept edge itself so all three counters come from the same cycle.
    assign capture   = accept && (req_sel == SEL_SNAP);

    perf_snapshot_bank #(
        .WIDTH(WIDTH)
    ) u_bank (
        .clk        (clk),
        .reset_n    (reset_n),
        .capture    (capture),
        .live_instr (instruction_count),
        .live_macc  (memory_access_count),
        .live_mcorr (memory_correction_count),
        .rd_sel     (sel_q),
        .rd_data    (bank_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            sel_q    <= SEL_INSTR;
            rsp_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_EXEC;
                        sel_q <= req_sel;
                    end
                end
                ST_EXEC: begin
                    rsp_data <= bank_data;
                    state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perf_counter_reader.sv
// Randomized bench for perf_counter_reader against a snapshot-history reference model.
// Honours PERF_READ_DELTA_EN the same way the design does.
module tb_perf_counter_reader;
    import perf_counter_reader_pkg::*;

    localparam int W = PERF_W;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] instr, macc, mcorr;
    logic         req_valid;
    logic [1:0]   req_sel;
    logic         req_ready;
    logic         rsp_valid;
    logic [W-1:0] rsp_data;
    logic         rsp_ready;

    int vectors;
    int miscompares;

    // Reference model: what each word read should return.
    logic [W-1:0] m_snap [3];
    logic [W-1:0] m_prev [3];

    perf_counter_reader #(.WIDTH(W)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .instruction_count       (instr),
        .memory_access_count     (macc),
        .memory_correction_count (mcorr),
        .req_valid               (req_valid),
        .req_sel                 (req_sel),
        .req_ready               (req_ready),
        .rsp_valid               (rsp_valid),
        .rsp_data                (rsp_data),
        .rsp_ready               (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_snap[k] = '0;
            m_prev[k] = '0;
        end
    endtask

    task automatic model_snapshot();
        logic [W-1:0] now [3];
        now[0] = instr;
        now[1] = macc;
        now[2] = mcorr;
        for (int k = 0; k < 3; k++) begin
`ifdef PERF_READ_DELTA_EN
            m_snap[k] = W'((32'(now[k]) + 32'h0010_0000 - 32'(m_prev[k])) % 32'h0010_0000);
            m_prev[k] = now[k];
`else
            m_snap[k] = now[k];
`endif
        end
    endtask

    // One full transaction, starting one time unit after a rising edge with the block idle.
    task automatic do_req(input logic [1:0] sel, input int hold, output logic [W-1:0] got);
        logic [W-1:0] exp;
        logic [W-1:0] held;
        check("idle_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_sel   = sel;
        rsp_ready = 1'b0;
        if (sel == SEL_SNAP) begin
            model_snapshot();
            exp = '0;
        end else begin
            exp = m_snap[sel];
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        instr = instr + 1'b1;
        macc  = macc + W'($urandom_range(0, 3));
        mcorr = mcorr + W'($urandom_range(0, 1));
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("exec_req_ready", 32'(req_ready), 32'd0);
        if (hold == 0) rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("resp_valid", 32'(rsp_valid), 32'd1);
        check("resp_data", 32'(rsp_data), 32'(exp));
        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_sel   = 2'($urandom_range(0, 3));
            instr     = instr + W'($urandom_range(1, 9));
            @(posedge clk); #1;
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_data", 32'(rsp_data), 32'(held));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("retire_rsp_valid", 32'(rsp_valid), 32'd0);
        check("retire_req_ready", 32'(req_ready), 32'd1);
        got = held;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [W-1:0] got;
        logic [W-1:0] exp_delta;
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_sel     = 2'd0;
        rsp_ready   = 1'b0;
        instr       = '0;
        macc        = '0;
        mcorr       = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;

        // Read before any snapshot.
        do_req(SEL_INSTR, 0, got);
        check("nosnap_sel0", 32'(got), 32'd0);

        // Snapshot 5/7/9, counters move on, reads still see the snapshot.
        instr = 20'd5; macc = 20'd7; mcorr = 20'd9;
        do_req(SEL_SNAP, 1, got);
        instr = 20'd50; macc = 20'd70; mcorr = 20'd90;
        do_req(SEL_INSTR, 0, got);
        check("snap_sel0", 32'(got), 32'd5);
        do_req(SEL_MACC, 2, got);
        check("snap_sel1", 32'(got), 32'd7);
        do_req(SEL_MCORR, 0, got);
        check("snap_sel2", 32'(got), 32'd9);
        do_req(SEL_INSTR, 10, got);
        check("repeat_sel0", 32'(got), 32'd5);

        // Wrap-around between two snapshots.
        instr = 20'hFFFF0;
        do_req(SEL_SNAP, 0, got);
        instr = 20'h00010;
        do_req(SEL_SNAP, 0, got);
`ifdef PERF_READ_DELTA_EN
        exp_delta = 20'h00020;
`else
        exp_delta = 20'h00010;
`endif
        do_req(SEL_INSTR, 0, got);
        check("wrap_sel0", 32'(got), 32'(exp_delta));

        // Counter increments 3->4 on the snapshot accept edge.
        do_req(SEL_SNAP, 0, got);
        instr = 20'd3;
        do_req(SEL_SNAP, 0, got);
        do_req(SEL_INSTR, 0, got);
`ifdef PERF_READ_DELTA_EN
        check("same_edge_sel0", 32'(got), 32'(m_snap[0]));
`else
        check("same_edge_sel0", 32'(got), 32'd3);
`endif

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            instr = W'($urandom);
            macc  = W'($urandom);
            mcorr = W'($urandom);
            do_req(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), got);
        end

        // Reset in the middle of a response.
        mcorr = 20'h12345;
        do_req(SEL_SNAP, 0, got);
        req_valid = 1'b1;
        req_sel   = SEL_MCORR;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("async_reset_req_ready", 32'(req_ready), 32'd1);
        check("async_reset_rsp_data", 32'(rsp_data), 32'd0);
        model_reset();
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_req(SEL_MCORR, 0, got);
        check("post_reset_sel2", 32'(got), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
